// File: rtl/reg_bus_master_if.sv
// reg_bus_master_if: serial byte handshake plus shared register bus signals.
// master = the bus initiator, slave = PHY and register-mapped modules.
interface reg_bus_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  reg_cmd;
    logic [15:0] reg_bytecount;
    logic [7:0]  reg_data_out;
    logic [7:0]  reg_data_in;
    logic        reg_read;
    logic        reg_write;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        input  reg_data_in,
        output tx_data,
        output tx_valid,
        output reg_cmd,
        output reg_bytecount,
        output reg_data_out,
        output reg_read,
        output reg_write
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output tx_ready,
        output reg_data_in,
        input  tx_data,
        input  tx_valid,
        input  reg_cmd,
        input  reg_bytecount,
        input  reg_data_out,
        input  reg_read,
        input  reg_write
    );
endinterface

// File: rtl/reg_bus_master.sv
// reg_bus_master: parses cmd/ctrl/data frames into register bus strobes.
// Define REG_WRITE_ACK_EN to transmit 8'hA5 after every write frame.
module reg_bus_master #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic             clk_usb,
    input  logic             reset,
    reg_bus_master_if.master bus,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        GET_CTRL,
        WR_DATA,
        RD_FETCH,
        RD_SEND
`ifdef REG_WRITE_ACK_EN
        , WR_ACK
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [6:0]  len_q, len_d;
    logic [23:0] tmo_q, tmo_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  dout_q, dout_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [7:0]  txd_q, txd_d;
    logic        txv_q, txv_d;

    logic [23:0] tmo_inc;
    logic        tmo_hit;
    logic [6:0]  idx_inc;
    logic        last;

    assign tmo_inc = tmo_q + 24'd1;
    assign tmo_hit = (TIMEOUT_CYCLES != 24'd0)
                  && (tmo_inc == TIMEOUT_CYCLES);
    assign idx_inc = idx_q + 7'd1;
    assign last    = (idx_q == len_q - 7'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        tmo_d   = '0;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        txd_d   = txd_q;
        txv_d   = txv_q;
        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    cmd_d   = bus.rx_data;
                    state_d = GET_CTRL;
                end
            end
            GET_CTRL: begin
                if (bus.rx_valid) begin
                    len_d = bus.rx_data[6:0];
                    idx_d = '0;
                    if (bus.rx_data[6:0] == 7'd0) begin
                        if (bus.rx_data[7]) begin
                            state_d = IDLE;
                        end else begin
`ifdef REG_WRITE_ACK_EN
                            state_d = WR_ACK;
                            txd_d   = 8'hA5;
                            txv_d   = 1'b1;
`else
                            state_d = IDLE;
`endif
                        end
                    end else if (bus.rx_data[7]) begin
                        // strobe is registered: raise it as RD_FETCH begins
                        state_d = RD_FETCH;
                        rd_d    = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = WR_DATA;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            WR_DATA: begin
                if (bus.rx_valid) begin
                    dout_d = bus.rx_data;
                    cnt_d  = {9'd0, idx_q};
                    wr_d   = 1'b1;
                    idx_d  = idx_inc;
                    if (last) begin
`ifdef REG_WRITE_ACK_EN
                        state_d = WR_ACK;
                        txd_d   = 8'hA5;
                        txv_d   = 1'b1;
`else
                        state_d = IDLE;
`endif
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            RD_FETCH: begin
                txd_d   = bus.reg_data_in;
                txv_d   = 1'b1;
                state_d = RD_SEND;
            end
            RD_SEND: begin
                if (bus.tx_ready) begin
                    txv_d = 1'b0;
                    idx_d = idx_inc;
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RD_FETCH;
                        rd_d    = 1'b1;
                        cnt_d   = {9'd0, idx_inc};
                    end
                end
            end
`ifdef REG_WRITE_ACK_EN
            WR_ACK: begin
                if (bus.tx_ready) begin
                    txv_d   = 1'b0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            tmo_q   <= '0;
            cmd_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            tmo_q   <= tmo_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
        end
    end

    assign bus.reg_cmd       = cmd_q;
    assign bus.reg_bytecount = cnt_q;
    assign bus.reg_data_out  = dout_q;
    assign bus.reg_read      = rd_q;
    assign bus.reg_write     = wr_q;
    assign bus.tx_data       = txd_q;
    assign bus.tx_valid      = txv_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: randomized frames checked against a list-based model.
// Build with REG_WRITE_ACK_EN to expect the A5 write acknowledge.
module tb_reg_bus_master;

`ifdef REG_WRITE_ACK_EN
    localparam int ACK = 1;
`else
    localparam int ACK = 0;
`endif

    logic clk_usb = 1'b0;
    logic reset;
    logic busy;
    reg_bus_master_if bus();

    logic [7:0] slave_mem [128];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stall_n = 0;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
        logic [7:0]  data;
        logic [7:0]  cmd;
    } ev_t;

    ev_t        wr_ev[$];
    ev_t        rd_ev[$];
    logic [7:0] tx_ev[$];
    int         rd_wide, overlap, hold_err;
    logic       prev_rd, prev_pend;
    logic [7:0] prev_txd;

    always #5 clk_usb = ~clk_usb;

    assign bus.reg_data_in = bus.reg_read
        ? slave_mem[bus.reg_bytecount[6:0]] : 8'h00;

    reg_bus_master #(.TIMEOUT_CYCLES(24'd16)) dut (
        .clk_usb(clk_usb),
        .reset(reset),
        .bus(bus),
        .busy(busy)
    );

    always @(posedge clk_usb) cyc <= cyc + 1;

    // bus monitor, sampled mid-cycle
    always @(negedge clk_usb) begin
        ev_t e;
        if (reset) begin
            prev_rd = 1'b0;
            prev_pend = 1'b0;
        end else begin
            e.cyc = cyc;
            e.cnt = bus.reg_bytecount;
            e.data = bus.reg_data_out;
            e.cmd = bus.reg_cmd;
            if (bus.reg_write) wr_ev.push_back(e);
            if (bus.reg_read) rd_ev.push_back(e);
            if (bus.reg_read && bus.reg_write) overlap++;
            if (bus.reg_read && prev_rd) rd_wide++;
            if (prev_pend && !(bus.tx_valid && bus.tx_data == prev_txd))
                hold_err++;
            if (bus.tx_valid && bus.tx_ready) tx_ev.push_back(bus.tx_data);
            prev_rd = bus.reg_read;
            prev_pend = bus.tx_valid && !bus.tx_ready;
            prev_txd = bus.tx_data;
        end
    end

    // transmitter: stalls stall_n cycles before accepting each byte
    initial begin
        int wc;
        wc = 0;
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk_usb);
            #1;
            if (!bus.tx_valid) begin
                wc = 0;
                bus.tx_ready = 1'b0;
            end else if (!bus.tx_ready) begin
                if (wc >= stall_n) bus.tx_ready = 1'b1;
                else wc++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(posedge clk_usb);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_usb);
            #1;
        end
    endtask

    task automatic clear_mon();
        wr_ev.delete();
        rd_ev.delete();
        tx_ev.delete();
        rd_wide = 0;
        overlap = 0;
        hold_err = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        idle(1);
        while ((busy || bus.tx_valid) && n < 3000) begin
            idle(1);
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL idle_wait busy=%0b want=0", busy);
        end
        idle(2);
    endtask

    task automatic test_reset();
        logic [42:0] v;
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        idle(3);
        reset = 1'b0;
        idle(1);
        v = {bus.tx_valid, bus.reg_read, bus.reg_write, busy,
             bus.reg_cmd, bus.reg_bytecount, bus.reg_data_out, bus.tx_data};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%0h want=0", v);
        end
    endtask

    task automatic test_write();
        logic [7:0] d [3];
        d[0] = 8'h40; d[1] = 8'h42; d[2] = 8'h0F;
        clear_mon();
        send_byte(8'h10);
        send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            send_byte(d[i]);
            idle(1);
        end
        wait_idle();
        total++;
        if (wr_ev.size() !== 3) begin
            bad++;
            $display("FAIL wr3_count got=%0d want=3", wr_ev.size());
        end
        for (int i = 0; i < 3 && i < wr_ev.size(); i++) begin
            total++;
            if ({wr_ev[i].cnt, wr_ev[i].data, wr_ev[i].cmd}
                !== {16'(i), d[i], 8'h10}) begin
                bad++;
                $display("FAIL wr3_ev%0d got=%0h/%0h/%0h want=%0h/%0h/10", i,
                         wr_ev[i].cnt, wr_ev[i].data, wr_ev[i].cmd, i, d[i]);
            end
        end
        total++;
        if (tx_ev.size() !== ACK || (ACK == 1 && tx_ev[0] !== 8'hA5)) begin
            bad++;
            $display("FAIL wr3_tx got=%0d bytes want=%0d", tx_ev.size(), ACK);
        end
        total++;
        if ({busy, rd_ev.size() == 0, bus.reg_bytecount, bus.reg_data_out}
            !== {1'b0, 1'b1, 16'd2, 8'h0F}) begin
            bad++;
            $display("FAIL wr3_idle got=%0b/%0h/%0h want=0/2/0f",
                     busy, bus.reg_bytecount, bus.reg_data_out);
        end
    endtask

    task automatic test_read_stall();
        logic [7:0] d [3];
        d[0] = 8'h40; d[1] = 8'h42; d[2] = 8'h0F;
        for (int i = 0; i < 3; i++) slave_mem[i] = d[i];
        stall_n = 5;
        clear_mon();
        send_byte(8'h10);
        send_byte(8'h83);
        wait_idle();
        stall_n = 0;
        total++;
        if (rd_ev.size() !== 3 || tx_ev.size() !== 3) begin
            bad++;
            $display("FAIL rd3_count got=%0d/%0d want=3/3",
                     rd_ev.size(), tx_ev.size());
        end
        for (int i = 0; i < 3 && i < tx_ev.size() && i < rd_ev.size(); i++) begin
            total++;
            if ({tx_ev[i], rd_ev[i].cnt} !== {d[i], 16'(i)}) begin
                bad++;
                $display("FAIL rd3_byte%0d got=%0h/%0h want=%0h/%0h", i,
                         tx_ev[i], rd_ev[i].cnt, d[i], i);
            end
        end
        // fetch + 5 stalled + accept cycle between read strobes
        for (int i = 1; i < rd_ev.size(); i++) begin
            total++;
            if (rd_ev[i].cyc - rd_ev[i-1].cyc !== 7) begin
                bad++;
                $display("FAIL rd3_spacing got=%0d want=7",
                         rd_ev[i].cyc - rd_ev[i-1].cyc);
            end
        end
        total++;
        if ({hold_err, rd_wide, overlap, wr_ev.size()} !== '0) begin
            bad++;
            $display("FAIL rd3_hygiene got=%0d/%0d/%0d/%0d want=0/0/0/0",
                     hold_err, rd_wide, overlap, wr_ev.size());
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        send_byte(8'h20);
        send_byte(8'h00);
        wait_idle();
        send_byte(8'h20);
        send_byte(8'h80);
        wait_idle();
        total++;
        if (wr_ev.size() + rd_ev.size() !== 0) begin
            bad++;
            $display("FAIL zero_strobes got=%0d want=0",
                     wr_ev.size() + rd_ev.size());
        end
        total++;
        if (tx_ev.size() !== ACK || (ACK == 1 && tx_ev[0] !== 8'hA5)) begin
            bad++;
            $display("FAIL zero_tx got=%0d want=%0d", tx_ev.size(), ACK);
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h55);
        idle(15);
        send_byte(8'h66);
        wait_idle();
        total++;
        if (wr_ev.size() !== 2 || tx_ev.size() !== ACK) begin
            bad++;
            $display("FAIL tmo15_writes got=%0d/%0d want=2/%0d",
                     wr_ev.size(), tx_ev.size(), ACK);
        end
        clear_mon();
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h55);
        idle(16);
        send_byte(8'h30);
        total++;
        if ({busy, bus.reg_cmd} !== {1'b1, 8'h30}) begin
            bad++;
            $display("FAIL tmo16_newcmd got=%0b/%0h want=1/30",
                     busy, bus.reg_cmd);
        end
        total++;
        if (wr_ev.size() !== 1 || tx_ev.size() !== 0) begin
            bad++;
            $display("FAIL tmo16_writes got=%0d/%0d want=1/0",
                     wr_ev.size(), tx_ev.size());
        end else if ({wr_ev[0].cnt, wr_ev[0].data} !== {16'd0, 8'h55}) begin
            bad++;
            $display("FAIL tmo16_ev got=%0h/%0h want=0/55",
                     wr_ev[0].cnt, wr_ev[0].data);
        end
        send_byte(8'h80);
        wait_idle();
    endtask

    task automatic test_reset_mid_read();
        int n;
        slave_mem[0] = 8'h3C;
        slave_mem[1] = 8'hC3;
        stall_n = 100000;
        clear_mon();
        send_byte(8'h11);
        send_byte(8'h82);
        n = 0;
        while (!bus.tx_valid && n < 50) begin
            idle(1);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL rst_wait_txv got=0 want=1");
        end
        idle(2);
        reset = 1'b1;
        idle(1);
        total++;
        if ({bus.tx_valid, bus.reg_read, bus.reg_write, busy} !== 4'b0) begin
            bad++;
            $display("FAIL rst_mid_read got=%0b%0b%0b%0b want=0000",
                     bus.tx_valid, bus.reg_read, bus.reg_write, busy);
        end
        reset = 1'b0;
        stall_n = 0;
        idle(1);
        total++;
        if (tx_ev.size() !== 0) begin
            bad++;
            $display("FAIL rst_dropped got=%0d want=0", tx_ev.size());
        end
        clear_mon();
        send_byte(8'h12);
        send_byte(8'h81);
        wait_idle();
        total++;
        if (rd_ev.size() !== 1 || tx_ev.size() !== 1) begin
            bad++;
            $display("FAIL rst_after got=%0d/%0d want=1/1",
                     rd_ev.size(), tx_ev.size());
        end else if ({tx_ev[0], rd_ev[0].cmd} !== {8'h3C, 8'h12}) begin
            bad++;
            $display("FAIL rst_after_data got=%0h/%0h want=3c/12",
                     tx_ev[0], rd_ev[0].cmd);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        clear_mon();
        send_byte(8'h44);
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) send_byte(d[i]);
        wait_idle();
        total++;
        if (wr_ev.size() !== 4) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=4", wr_ev.size());
        end
        for (int i = 0; i < 4 && i < wr_ev.size(); i++) begin
            total++;
            if ({wr_ev[i].cnt, wr_ev[i].data, wr_ev[i].cyc - wr_ev[0].cyc}
                !== {16'(i), d[i], i}) begin
                bad++;
                $display("FAIL b2b_ev%0d got=%0h/%0h/+%0d want=%0h/%0h/+%0d",
                         i, wr_ev[i].cnt, wr_ev[i].data,
                         wr_ev[i].cyc - wr_ev[0].cyc, i, d[i], i);
            end
        end
        total++;
        if (tx_ev.size() !== ACK || (ACK == 1 && tx_ev[0] !== 8'hA5)) begin
            bad++;
            $display("FAIL b2b_tx got=%0d want=%0d", tx_ev.size(), ACK);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            logic [7:0] cmd;
            logic       rd;
            int         len;
            logic [7:0] d [12];
            ev_t        exp_wr[$];
            int         exp_rd[$];
            logic [7:0] exp_tx[$];
            ev_t        e;
            cmd = 8'($urandom);
            rd = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 12);
            stall_n = $urandom_range(0, 3);
            for (int i = 0; i < 128; i++) slave_mem[i] = 8'($urandom);
            for (int i = 0; i < 12; i++) d[i] = 8'($urandom);
            for (int i = 0; i < len; i++) begin
                if (rd) begin
                    exp_rd.push_back(i);
                    exp_tx.push_back(slave_mem[i]);
                end else begin
                    e.cyc = 0;
                    e.cnt = 16'(i);
                    e.data = d[i];
                    e.cmd = cmd;
                    exp_wr.push_back(e);
                end
            end
            if (!rd && ACK == 1) exp_tx.push_back(8'hA5);
            clear_mon();
            send_byte(cmd);
            idle($urandom_range(0, 3));
            send_byte({rd, 7'(len)});
            if (!rd) begin
                for (int i = 0; i < len; i++) begin
                    idle($urandom_range(0, 3));
                    send_byte(d[i]);
                end
            end
            wait_idle();
            total++;
            if ({wr_ev.size(), rd_ev.size(), tx_ev.size()}
                !== {exp_wr.size(), exp_rd.size(), exp_tx.size()}) begin
                bad++;
                $display("FAIL rnd%0d_sizes got=%0d/%0d/%0d want=%0d/%0d/%0d",
                         f, wr_ev.size(), rd_ev.size(), tx_ev.size(),
                         exp_wr.size(), exp_rd.size(), exp_tx.size());
            end
            for (int i = 0; i < exp_wr.size() && i < wr_ev.size(); i++) begin
                total++;
                if ({wr_ev[i].cnt, wr_ev[i].data, wr_ev[i].cmd}
                    !== {exp_wr[i].cnt, exp_wr[i].data, exp_wr[i].cmd}) begin
                    bad++;
                    $display("FAIL rnd%0d_wr%0d got=%0h/%0h/%0h want=%0h/%0h/%0h",
                             f, i, wr_ev[i].cnt, wr_ev[i].data, wr_ev[i].cmd,
                             exp_wr[i].cnt, exp_wr[i].data, exp_wr[i].cmd);
                end
            end
            for (int i = 0; i < exp_rd.size() && i < rd_ev.size(); i++) begin
                total++;
                if ({rd_ev[i].cnt, rd_ev[i].cmd} !== {16'(exp_rd[i]), cmd}) begin
                    bad++;
                    $display("FAIL rnd%0d_rd%0d got=%0h/%0h want=%0h/%0h",
                             f, i, rd_ev[i].cnt, rd_ev[i].cmd, exp_rd[i], cmd);
                end
            end
            for (int i = 0; i < exp_tx.size() && i < tx_ev.size(); i++) begin
                total++;
                if (tx_ev[i] !== exp_tx[i]) begin
                    bad++;
                    $display("FAIL rnd%0d_tx%0d got=%0h want=%0h",
                             f, i, tx_ev[i], exp_tx[i]);
                end
            end
            total++;
            if ({hold_err, rd_wide, overlap} !== '0) begin
                bad++;
                $display("FAIL rnd%0d_hygiene got=%0d/%0d/%0d want=0/0/0",
                         f, hold_err, rd_wide, overlap);
            end
        end
        stall_n = 0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) slave_mem[i] = 8'h00;
        rd_wide = 0;
        overlap = 0;
        hold_err = 0;
        prev_rd = 1'b0;
        prev_pend = 1'b0;
        prev_txd = 8'h00;
        test_reset();
        test_write();
        test_read_stall();
        test_zero_len();
        test_timeout();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
